// File: rtl/core_sram_controller_if.sv
// Core-side memory port of the RV32 core, as seen by the SRAM controller.
`timescale 1ns/1ps

interface core_sram_controller_if;
    logic [31:0] memoryAddress;
    logic [3:0]  memoryByteSelect;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic [31:0] memoryDataWrite;
    logic [31:0] memoryDataRead;
    logic        memoryBusy;
    logic        memoryAccessFault;

    modport master (
        output memoryAddress,
        output memoryByteSelect,
        output memoryReadEnable,
        output memoryWriteEnable,
        output memoryDataWrite,
        input  memoryDataRead,
        input  memoryBusy,
        input  memoryAccessFault
    );

    modport slave (
        input  memoryAddress,
        input  memoryByteSelect,
        input  memoryReadEnable,
        input  memoryWriteEnable,
        input  memoryDataWrite,
        output memoryDataRead,
        output memoryBusy,
        output memoryAccessFault
    );
endinterface

// File: rtl/core_sram_controller.sv
// Bridges the core memory port to a single-port SRAM with one-cycle read latency.
// Misaligned accesses that cross a word boundary are split into two SRAM cycles.
`timescale 1ns/1ps

module core_sram_controller #(
    parameter int unsigned ADDRESS_BITS = 9,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rstb,
    core_sram_controller_if.slave   bus,
    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [3:0]              sram_wmask0,
    output logic [ADDRESS_BITS-1:0] sram_addr0,
    output logic [31:0]             sram_din0,
    input  logic [31:0]             sram_dout0
);

    localparam int unsigned TAG_LSB = ADDRESS_BITS + 2;

    typedef enum logic [1:0] {
        IDLE,
        READ_LO,
        READ_HI,
        WRITE_HI
    } ControllerState;

    ControllerState state;
    ControllerState nextState;

    logic [31:0]             lowWord;
    logic                    request;
    logic [1:0]              offset;
    logic [7:0]              wideMask;
    logic                    split;
    logic [ADDRESS_BITS-1:0] wordA;
    logic [ADDRESS_BITS-1:0] wordB;
    logic                    inRange;
    logic [63:0]             wideWrite;
    logic [31:0]             byteMaskBits;
    logic [31:0]             alignedLo;
    logic [31:0]             alignedHi;

    assign request      = rstb && (bus.memoryReadEnable || bus.memoryWriteEnable);
    assign offset       = bus.memoryAddress[1:0];
    assign wideMask     = {4'b0000, bus.memoryByteSelect} << offset;
    assign split        = |wideMask[7:4];
    assign wordA        = bus.memoryAddress[TAG_LSB-1:2];
    assign wordB        = wordA + ADDRESS_BITS'(1);
    assign inRange      = (bus.memoryAddress[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB])
                          && !(split && (&wordA));
    assign wideWrite    = {32'h0000_0000, bus.memoryDataWrite} << {offset, 3'b000};
    assign byteMaskBits = {{8{bus.memoryByteSelect[3]}}, {8{bus.memoryByteSelect[2]}},
                           {8{bus.memoryByteSelect[1]}}, {8{bus.memoryByteSelect[0]}}};
    assign alignedLo    = sram_dout0 >> {offset, 3'b000};
    assign alignedHi    = 32'({sram_dout0, lowWord} >> {offset, 3'b000});

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Hold the first word of a split read while the second word is fetched.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            lowWord <= '0;
        end else if (state == READ_LO && split) begin
            lowWord <= sram_dout0;
        end
    end

    // Next-state logic plus SRAM pin and core-response decoding.
    always_comb begin
        nextState             = state;
        sram_csb0             = 1'b1;
        sram_web0             = 1'b1;
        sram_wmask0           = 4'b0000;
        sram_addr0            = '0;
        sram_din0             = '0;
        bus.memoryBusy        = 1'b0;
        bus.memoryAccessFault = 1'b0;
        bus.memoryDataRead    = '0;

        if (rstb) begin
            case (state)
                IDLE: begin
                    if (request) begin
                        if (!inRange) begin
                            bus.memoryAccessFault = 1'b1;
                        end else if (bus.memoryWriteEnable) begin
                            sram_csb0   = 1'b0;
                            sram_web0   = 1'b0;
                            sram_wmask0 = wideMask[3:0];
                            sram_addr0  = wordA;
                            sram_din0   = wideWrite[31:0];
                            if (split) begin
                                bus.memoryBusy = 1'b1;
                                nextState      = WRITE_HI;
                            end
                        end else begin
                            sram_csb0      = 1'b0;
                            sram_addr0     = wordA;
                            bus.memoryBusy = 1'b1;
                            nextState      = READ_LO;
                        end
                    end
                end
                READ_LO: begin
                    if (split) begin
                        sram_csb0      = 1'b0;
                        sram_addr0     = wordB;
                        bus.memoryBusy = 1'b1;
                        nextState      = READ_HI;
                    end else begin
                        bus.memoryDataRead = alignedLo & byteMaskBits;
                        nextState          = IDLE;
                    end
                end
                READ_HI: begin
                    bus.memoryDataRead = alignedHi & byteMaskBits;
                    nextState          = IDLE;
                end
                WRITE_HI: begin
                    sram_csb0   = 1'b0;
                    sram_web0   = 1'b0;
                    sram_wmask0 = wideMask[7:4];
                    sram_addr0  = wordB;
                    sram_din0   = wideWrite[63:32];
                    nextState   = IDLE;
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sram_controller.sv
// Bench for core_sram_controller: SRAM macro model plus a byte-addressed reference memory.
`timescale 1ns/1ps

module tb_core_sram_controller;

    logic        clk = 1'b0;
    logic        rstb;
    logic        sram_csb0;
    logic        sram_web0;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;

    logic        preloadEnable;
    logic [8:0]  preloadIndex;
    logic [31:0] preloadData;

    logic [31:0] sramMem [512];
    logic [7:0]  refMem [2048];

    int checks = 0;
    int errors = 0;

    core_sram_controller_if bus ();

    core_sram_controller #(
        .ADDRESS_BITS (9),
        .BASE_ADDRESS (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .bus         (bus),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural SRAM macro: masked writes, registered read data.
    always @(posedge clk) begin
        if (preloadEnable) begin
            sramMem[preloadIndex] <= preloadData;
        end else if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask0[b]) sramMem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
                end
            end else begin
                sram_dout0 <= sramMem[sram_addr0];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [3:0] sel, input logic [31:0] data, input string tag);
        int          n;
        longint      lastByte;
        bit          isWrite;
        bit          expFault;
        bit          split;
        int          expBusy;
        int          cyc;
        bit          done;
        int          baseWord;
        int          idx;
        logic [31:0] expData;
        logic [31:0] obsData;
        logic [31:0] expDin;
        logic [3:0]  expMask;
        logic [31:0] laneBits;

        n        = (sel == 4'b0001) ? 1 : ((sel == 4'b0011) ? 2 : 4);
        isWrite  = wr;
        lastByte = longint'(addr) + longint'(n) - 1;
        expFault = (longint'(addr) >= 2048) || (lastByte >= 2048);
        split    = (int'(addr[1:0]) + n) > 4;
        expBusy  = 0;
        expData  = '0;
        if (!expFault) begin
            expBusy = isWrite ? int'(split) : 1 + int'(split);
            if (!isWrite) begin
                for (int i = 0; i < n; i++) expData[8*i +: 8] = refMem[int'(addr) + i];
            end
        end

        bus.memoryAddress     = addr;
        bus.memoryByteSelect  = sel;
        bus.memoryDataWrite   = data;
        bus.memoryWriteEnable = wr;
        bus.memoryReadEnable  = rd;

        cyc     = 0;
        done    = 0;
        obsData = '0;
        while (!done && cyc <= 4) begin
            #1;
            if (expFault) begin
                checkOutput({tag, " fault"}, {31'b0, bus.memoryAccessFault}, 32'd1);
                checkOutput({tag, " faultBusy"}, {31'b0, bus.memoryBusy}, 32'd0);
                checkOutput({tag, " faultCsb"}, {31'b0, sram_csb0}, 32'd1);
                done = 1;
            end else begin
                checkOutput({tag, " noFault"}, {31'b0, bus.memoryAccessFault}, 32'd0);
                if (isWrite || cyc < expBusy) begin
                    checkOutput({tag, " csb"}, {31'b0, sram_csb0}, 32'd0);
                    checkOutput({tag, " web"}, {31'b0, sram_web0}, isWrite ? 32'd0 : 32'd1);
                    checkOutput({tag, " addr"}, {23'b0, sram_addr0}, ((addr >> 2) + cyc) & 32'h1FF);
                    if (isWrite) begin
                        baseWord = (int'(addr) >> 2) + cyc;
                        expMask  = '0;
                        expDin   = '0;
                        for (int p = 0; p < 4; p++) begin
                            idx = baseWord * 4 + p - int'(addr);
                            if (idx >= 0 && idx < n) begin
                                expMask[p]       = 1'b1;
                                expDin[8*p +: 8] = data[8*idx +: 8];
                            end
                        end
                        laneBits = {{8{expMask[3]}}, {8{expMask[2]}}, {8{expMask[1]}}, {8{expMask[0]}}};
                        checkOutput({tag, " wmask"}, {28'b0, sram_wmask0}, {28'b0, expMask});
                        checkOutput({tag, " din"}, sram_din0 & laneBits, expDin);
                    end
                end else begin
                    checkOutput({tag, " csbIdle"}, {31'b0, sram_csb0}, 32'd1);
                end
                if (bus.memoryBusy) begin
                    checkOutput({tag, " dataWhileBusy"}, bus.memoryDataRead, 32'd0);
                    cyc++;
                end else begin
                    obsData = bus.memoryDataRead;
                    done    = 1;
                end
            end
            @(negedge clk);
        end

        checkOutput({tag, " completed"}, {31'b0, done}, 32'd1);
        checkOutput({tag, " busyCycles"}, cyc, expBusy);
        if (!expFault) checkOutput({tag, " data"}, obsData, expData);

        if (isWrite && !expFault) begin
            for (int i = 0; i < n; i++) refMem[int'(addr) + i] = data[8*i +: 8];
        end

        bus.memoryWriteEnable = 1'b0;
        bus.memoryReadEnable  = 1'b0;
    endtask

    // Directed steps followed by randomized back-to-back traffic.
    initial begin
        logic [31:0] rAddr;
        logic [3:0]  rSel;
        int          op;
        int          pick;

        rstb                  = 1'b0;
        preloadEnable         = 1'b0;
        preloadIndex          = '0;
        preloadData           = '0;
        bus.memoryAddress     = 32'h16;
        bus.memoryByteSelect  = 4'b1111;
        bus.memoryDataWrite   = '0;
        bus.memoryWriteEnable = 1'b0;
        bus.memoryReadEnable  = 1'b1;

        @(negedge clk);
        preloadEnable = 1'b1;
        for (int w = 0; w < 512; w++) begin
            preloadIndex = 9'(w);
            preloadData  = $urandom;
            for (int b = 0; b < 4; b++) refMem[4*w + b] = preloadData[8*b +: 8];
            @(negedge clk);
        end
        preloadEnable = 1'b0;

        #1;
        checkOutput("reset busy", {31'b0, bus.memoryBusy}, 32'd0);
        checkOutput("reset fault", {31'b0, bus.memoryAccessFault}, 32'd0);
        checkOutput("reset data", bus.memoryDataRead, 32'd0);
        checkOutput("reset csb", {31'b0, sram_csb0}, 32'd1);
        checkOutput("reset web", {31'b0, sram_web0}, 32'd1);
        checkOutput("reset wmask", {28'b0, sram_wmask0}, 32'd0);
        @(negedge clk);
        rstb                 = 1'b1;
        bus.memoryReadEnable = 1'b0;
        @(negedge clk);

        applyStimulus(1, 0, 32'h10, 4'b1111, 32'hDEADBEEF, "alignedWrite");
        applyStimulus(0, 1, 32'h10, 4'b1111, 32'h0, "alignedRead");
        applyStimulus(1, 0, 32'h10, 4'b1111, 32'h11223344, "wordWrite");
        applyStimulus(1, 0, 32'h13, 4'b0001, 32'h000000AB, "byteWrite");
        applyStimulus(0, 1, 32'h10, 4'b1111, 32'h0, "wordAfterByte");
        applyStimulus(0, 1, 32'h13, 4'b0001, 32'h0, "byteRead");
        applyStimulus(1, 0, 32'h16, 4'b1111, 32'hCAFEF00D, "splitWrite");
        applyStimulus(0, 1, 32'h16, 4'b1111, 32'h0, "splitRead");
        applyStimulus(0, 1, 32'h800, 4'b1111, 32'h0, "faultAbove");
        applyStimulus(0, 1, 32'h7FF, 4'b0011, 32'h0, "faultWrap");
        applyStimulus(1, 0, 32'h1000_0000, 4'b1111, 32'h12345678, "faultWrite");
        applyStimulus(1, 0, 32'h7FC, 4'b1111, 32'h0BADF00D, "lastWordWrite");
        applyStimulus(0, 1, 32'h7FE, 4'b0011, 32'h0, "lastHalfRead");
        applyStimulus(1, 1, 32'h20, 4'b1111, 32'h5A5AA5A5, "bothEnables");
        applyStimulus(0, 1, 32'h20, 4'b1111, 32'h0, "readBack20");

        bus.memoryAddress    = 32'h16;
        bus.memoryByteSelect = 4'b1111;
        bus.memoryReadEnable = 1'b1;
        #1;
        checkOutput("midReset issueBusy", {31'b0, bus.memoryBusy}, 32'd1);
        @(negedge clk);
        #1;
        checkOutput("midReset secondBusy", {31'b0, bus.memoryBusy}, 32'd1);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        checkOutput("midReset busy", {31'b0, bus.memoryBusy}, 32'd0);
        checkOutput("midReset data", bus.memoryDataRead, 32'd0);
        checkOutput("midReset csb", {31'b0, sram_csb0}, 32'd1);
        @(negedge clk);
        rstb                 = 1'b1;
        bus.memoryReadEnable = 1'b0;
        #1;
        checkOutput("afterReset busy", {31'b0, bus.memoryBusy}, 32'd0);
        checkOutput("afterReset data", bus.memoryDataRead, 32'd0);
        checkOutput("afterReset csb", {31'b0, sram_csb0}, 32'd1);
        @(negedge clk);
        applyStimulus(0, 1, 32'h10, 4'b1111, 32'h0, "readAfterReset");

        for (int t = 0; t < 300; t++) begin
            op   = int'($urandom_range(0, 2));
            pick = int'($urandom_range(0, 9));
            if (pick == 0)      rAddr = $urandom;
            else if (pick == 1) rAddr = 32'h7F0 + $urandom_range(0, 15);
            else if (pick < 5)  rAddr = $urandom_range(0, 63);
            else                rAddr = $urandom_range(0, 2047);
            case ($urandom_range(0, 2))
                0:       rSel = 4'b0001;
                1:       rSel = 4'b0011;
                default: rSel = 4'b1111;
            endcase
            applyStimulus(op != 1, op != 0, rAddr, rSel, $urandom, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sram_controller.md
# core_sram_controller

Bridges the RV32ICore data/instruction memory port (`memoryAddress`, `memoryByteSelect`, `memoryReadEnable`, `memoryWriteEnable`, `memoryDataWrite`, `memoryDataRead`, `memoryBusy`, `memoryAccessFault`) to a single-port 32-bit synchronous SRAM macro with one-cycle read latency. It sits directly downstream of the core and replaces the zero-latency behavioural memory used in core-level benches. It decodes the SRAM address window, stalls the core with `memoryBusy` for read latency, and splits misaligned accesses that cross a word boundary into two SRAM cycles.

## Interface
- `ADDRESS_BITS`, 9, SRAM word-address width; window size = 4·2^ADDRESS_BITS bytes
- `BASE_ADDRESS`, 32'h0000_0000, window base; aligned to window size
- `clk`  in  1  clock; SRAM macro shares it
- `rstb`  in  1  reset, synchronous, active-low
- `memoryAddress`  in  32  byte address from core
- `memoryByteSelect`  in  4  contiguous byte mask relative to `memoryAddress`: 0001, 0011 or 1111
- `memoryWriteEnable`  in  1  write request; held by core while `memoryBusy`
- `memoryReadEnable`  in  1  read request; held by core while `memoryBusy`
- `memoryDataWrite`  in  32  write data, byte 0 at `memoryAddress`
- `memoryDataRead`  out  32  read data, byte 0 at `memoryAddress`; unselected bytes zero
- `memoryBusy`  out  1  core must hold request and not sample data
- `memoryAccessFault`  out  1  address outside window
- `sram_csb0`  out  1  chip select, active-low
- `sram_web0`  out  1  write enable, active-low
- `sram_wmask0`  out  4  byte write mask
- `sram_addr0`  out  ADDRESS_BITS  word address
- `sram_din0`  out  32  write data
- `sram_dout0`  in  32  read data, valid the cycle after a read is sampled

## Operation
- States: IDLE, READ_LO (first word in flight), READ_HI (second word in flight), WRITE_HI.
- Request = rstb && (readEnable || writeEnable); write has priority if both asserted.
- offset = addr[1:0]; wide mask M[7:0] = {4'b0, byteSelect} << offset; split = |M[7:4]; wordA = addr[ADDRESS_BITS+1:2], wordB = wordA+1.
- In range: addr[31:ADDRESS_BITS+2] equals BASE and, if split, wordA is not the last word (no wrap). Otherwise `memoryAccessFault`=1, `memoryBusy`=0, SRAM untouched, same cycle, state stays IDLE.
- Write data: W[63:0] = {32'b0, dataWrite} << 8·offset.
- IDLE write, not split: csb0=0, web0=0, wmask0=M[3:0], addr0=wordA, din0=W[31:0]; busy=0; stay IDLE.
- IDLE write, split: same with low half; busy=1; → WRITE_HI. WRITE_HI: write wordB, wmask0=M[7:4], din0=W[63:32]; busy=0; → IDLE.
- IDLE read: csb0=0, web0=1, addr0=wordA; busy=1; → READ_LO.
- READ_LO not split: dataRead = (dout0 >> 8·offset) masked by byteSelect; busy=0; → IDLE.
- READ_LO split: latch dout0 into lowWord; issue read of wordB; busy=1; → READ_HI. READ_HI: dataRead = ({dout0, lowWord} >> 8·offset)[31:0] masked; busy=0; → IDLE.
- Outside completion cycles `memoryDataRead` = 0.
- Idle SRAM pins: csb0=1, web0=1, wmask0=0, addr0/din0 = 0.

## Timing
- Reset (rstb low at edge): state → IDLE, lowWord → 0. While rstb low, all SRAM outputs idle and busy/fault/dataRead = 0 combinationally. Reset mid-split abandons the access; a half-written split write is not rolled back.
- Aligned write: 1 cycle, no stall. Split write: 2 cycles, 1 stall.
- Aligned read: 2 cycles (data returned in cycle 1). Split read: 3 cycles.
- Fault: 0 stall, combinational.
- Request dropped in a non-IDLE state: FSM still completes its sequence (core protocol forbids it; no recovery required).
- Back-to-back: a new request in the cycle after completion is accepted from IDLE with no bubble.

## Test plan
- Aligned write 0xDEADBEEF to 0x10, sel 1111, then read 0x10 -> busy 0 on write; read busy 1 for one cycle then dataRead 0xDEADBEEF.
- Byte write 0xAB at 0x13 (sel 0001) over word 0x11223344 -> wmask0 1000, read word 0x10 returns 0xAB223344; byte read at 0x13 returns 0x000000AB.
- Split word write 0xCAFEF00D at 0x16 -> two SRAM writes (wordA mask 1100, wordB mask 0011), busy 1 then 0; split read at 0x16 takes 3 cycles and returns 0xCAFEF00D.
- Read at 0x0000_0800 (ADDRESS_BITS=9) and halfword at 0x7FF -> memoryAccessFault 1, busy 0, csb0 stays 1 in the same cycle.
- Both enables asserted, address 0x20 -> write performed, no read issued.
- rstb low during READ_HI of a split read -> next cycle IDLE, csb0 1, busy 0; subsequent aligned read returns correct data.
